// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: arbitrates write/read burst requests onto a single MCB command port
// Ports:
//   ddr_usrclk, ddr_usrreset   clock, synchronous active-high reset
//   ddr_cal_done               calibration complete; gates all commands
//   wr_req, wr_restart, wr_ack write burst request, pointer restart, issue ack
//   rd_req, rd_addr, rd_ack    read burst request, byte address, issue ack
//   cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_full   MCB command port
//   wr_ptr, wrapped, busy      ring write pointer, sticky wrap flag, not-idle
// Optional: DDR_ARB_STARVE_GUARD_EN forces a read after STARVE_MAX writes granted over it
module ddr_cmd_arbiter #(
    parameter int BURST_BYTES = 256,
    parameter int RING_BYTES  = 33554432,
    parameter int STARVE_MAX  = 4
) (
    input  logic        ddr_usrclk,
    input  logic        ddr_usrreset,
    input  logic        ddr_cal_done,
    input  logic        wr_req,
    input  logic        wr_restart,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    output logic        rd_ack,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic [29:0] wr_ptr,
    output logic        wrapped,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE} state_t;
    localparam logic [29:0] LAST  = 30'(RING_BYTES - BURST_BYTES);
    localparam logic [29:0] BURST = 30'(BURST_BYTES);
    state_t      r_state, w_next;
    logic        r_is_rd;
    logic [29:0] r_addr, r_wr_ptr;
    logic        r_wrapped;
    logic        w_grant, w_pick_rd, w_force_rd, w_issue;
    assign w_issue   = r_state == S_ISSUE;
    assign w_grant   = r_state == S_ARB && ddr_cal_done && (wr_req || rd_req) && !cmd_full;
    assign w_pick_rd = rd_req && (!wr_req || w_force_rd);
    assign cmd_en        = w_issue;
    assign wr_ack        = w_issue && !r_is_rd;
    assign rd_ack        = w_issue && r_is_rd;
    assign cmd_instr     = {2'b00, r_is_rd};
    assign cmd_bl        = 6'd63;
    assign cmd_byte_addr = r_addr;
    assign wr_ptr        = r_wr_ptr;
    assign wrapped       = r_wrapped;
    assign busy          = r_state != S_IDLE;
    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) r_state <= S_IDLE;
        else              r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = ddr_cal_done ? S_ARB : S_IDLE;
            S_ARB:   w_next = !ddr_cal_done ? S_IDLE : (w_grant ? S_ISSUE : S_ARB);
            S_ISSUE: w_next = S_ARB;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            r_is_rd   <= 1'b0;
            r_addr    <= '0;
            r_wr_ptr  <= '0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_grant) begin
                r_is_rd <= w_pick_rd;
                r_addr  <= w_pick_rd ? (rd_addr & ~30'd3) : r_wr_ptr;
            end
            // restart wins over the post-issue increment; the issuing command already holds its address
            if (wr_restart) begin
                r_wr_ptr  <= '0;
                r_wrapped <= 1'b0;
            end else if (w_issue && !r_is_rd) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + BURST;
                if (r_wr_ptr == LAST) r_wrapped <= 1'b1;
            end
        end
    end
`ifdef DDR_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] r_starve;
    // counter saturates naturally: at STARVE_MAX with rd_req pending the read wins and clears it
    assign w_force_rd = r_starve == CW'(STARVE_MAX);
    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset)             r_starve <= '0;
        else if (w_grant && w_pick_rd) r_starve <= '0;
        else if (w_grant && rd_req)    r_starve <= r_starve + CW'(1);
    end
`else
    assign w_force_rd = STARVE_MAX < 0;
`endif
endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb_ddr_cmd_arbiter: directed checks of the DDR command arbiter with a 1 KiB ring
module tb_ddr_cmd_arbiter;
    logic clk = 1'b0, rst = 1'b1, cal = 1'b0, wr_req = 1'b0, wr_restart = 1'b0;
    logic rd_req = 1'b0, cmd_full = 1'b0;
    logic [29:0] rd_addr = '0;
    logic wr_ack, rd_ack, cmd_en, wrapped, busy;
    logic [2:0] cmd_instr;
    logic [5:0] cmd_bl;
    logic [29:0] cmd_byte_addr, wr_ptr;
    int total = 0, bad = 0;
    int q_addr[$], q_instr[$], q_cyc[$], q_ack[$];
    int n;
    always #5 clk = ~clk;
    ddr_cmd_arbiter #(.BURST_BYTES(256), .RING_BYTES(1024), .STARVE_MAX(4)) dut (
        .ddr_usrclk(clk), .ddr_usrreset(rst), .ddr_cal_done(cal),
        .wr_req(wr_req), .wr_restart(wr_restart), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_ptr(wr_ptr), .wrapped(wrapped), .busy(busy));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic issue_wait(input int cnt, input int max);
        q_addr.delete(); q_instr.delete(); q_cyc.delete(); q_ack.delete();
        for (int c = 0; c < max && q_addr.size() < cnt; c++) begin
            @(negedge clk);
            if (cmd_en) begin
                q_addr.push_back(int'(cmd_byte_addr));
                q_instr.push_back(int'(cmd_instr));
                q_cyc.push_back(c);
                q_ack.push_back(int'({rd_ack, wr_ack}));
            end
        end
        chk("issue_count", q_addr.size(), cnt);
        while (q_addr.size() < cnt) begin
            q_addr.push_back(-1); q_instr.push_back(-1); q_cyc.push_back(-1); q_ack.push_back(-1);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_instr", cmd_instr, 0);
        chk("rst_addr", cmd_byte_addr, 0);
        chk("rst_acks", {rd_ack, wr_ack}, 0);
        chk("cmd_bl", cmd_bl, 63);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_cal", busy, 0);
        // three back-to-back writes
        cal = 1'b1; wr_req = 1'b1;
        issue_wait(3, 20);
        wr_req = 1'b0;
        chk("w0_addr", q_addr[0], 32'h000);
        chk("w1_addr", q_addr[1], 32'h100);
        chk("w2_addr", q_addr[2], 32'h200);
        chk("w0_lat", q_cyc[0], 1);
        chk("w_gap01", q_cyc[1] - q_cyc[0], 2);
        chk("w_gap12", q_cyc[2] - q_cyc[1], 2);
        chk("w0_ack", q_ack[0], 1);
        chk("w2_instr", q_instr[2], 0);
        @(negedge clk);
        chk("ptr_300", wr_ptr, 32'h300);
        chk("no_extra_en", cmd_en, 0);
        chk("busy_arb", busy, 1);
        // 4th write at ring end, 5th wraps to 0
        wr_req = 1'b1;
        issue_wait(1, 6);
        chk("w3_addr", q_addr[0], 32'h300);
        chk("w3_wrapped_pre", wrapped, 0);
        issue_wait(1, 6);
        wr_req = 1'b0;
        chk("w4_addr", q_addr[0], 32'h000);
        chk("w4_wrapped", wrapped, 1);
        @(negedge clk);
        chk("ptr_after_wrap", wr_ptr, 32'h100);
        // restart coinciding with issue at 0x300
        wr_req = 1'b1;
        issue_wait(3, 12);
        wr_req = 1'b0; wr_restart = 1'b1;
        chk("rs_addr", q_addr[2], 32'h300);
        @(negedge clk);
        wr_restart = 1'b0;
        chk("rs_ptr", wr_ptr, 0);
        chk("rs_wrapped", wrapped, 0);
        // word-aligned read
        rd_req = 1'b1; rd_addr = 30'h1237;
        issue_wait(1, 6);
        rd_req = 1'b0;
        chk("rd_instr", q_instr[0], 1);
        chk("rd_addr", q_addr[0], 32'h1234);
        chk("rd_ack", q_ack[0], 2);
        n = 0;
        repeat (6) begin @(negedge clk); n += int'(rd_ack) + int'(cmd_en); end
        chk("rd_once", n, 0);
        chk("rd_ptr_hold", wr_ptr, 0);
        // command FIFO full blocks issue
        cmd_full = 1'b1; wr_req = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(cmd_en); end
        chk("full_block", n, 0);
        cmd_full = 1'b0;
        issue_wait(1, 6);
        chk("full_release", q_cyc[0] <= 1, 1);
        chk("full_rel_addr", q_addr[0], 0);
        wr_req = 1'b0;
        @(negedge clk);
        // both requests held
        wr_req = 1'b1; rd_req = 1'b1; rd_addr = 30'h40;
        issue_wait(10, 40);
`ifdef DDR_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 10; i++) chk($sformatf("starve_%0d", i), q_instr[i], (i % 5 == 4) ? 1 : 0);
`else
        n = 0;
        for (int i = 0; i < 10; i++) n += q_instr[i];
        chk("strict_wr", n, 0);
`endif
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        // calibration loss during issue completes the command
        wr_req = 1'b1;
        issue_wait(1, 6);
        cal = 1'b0;
        chk("cal_issue_en", cmd_en, 1);
        @(negedge clk);
        chk("cal_arb_en", cmd_en, 0);
        chk("cal_arb_busy", busy, 1);
        @(negedge clk);
        chk("cal_idle", busy, 0);
        // reset during issue
        cal = 1'b1;
        issue_wait(1, 8);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_iss_en", cmd_en, 0);
        chk("rst_iss_ack", {rd_ack, wr_ack}, 0);
        chk("rst_iss_busy", busy, 0);
        chk("rst_iss_ptr", wr_ptr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
